// File: rtl/proc_ctrl_seq.sv
// Multi-cycle instruction sequencer for one distributed-processor core.
// Decodes the opcode class and drives datapath selects, enables and fproc/sync handshakes.
module proc_ctrl_seq #(
  parameter int WAIT_TIMEOUT = 0,
  parameter int CNT_W        = 16,
  parameter int ILLEGAL_TRAP = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] opcode,
  input  logic       fproc_ready,
  input  logic       sync_enable,
  input  logic       cstrobe_in,
  output logic [2:0] alu_opcode,
  output logic       alu_in0_sel,
  output logic [1:0] alu_in1_sel,
  output logic       c_strobe_enable,
  output logic       reg_write_en,
  output logic       instr_ptr_en,
  output logic [1:0] instr_ptr_load_en,
  output logic       qclk_load_en,
  output logic       sync_out_ready,
  output logic       fproc_out_ready,
  output logic       write_pulse_en,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  typedef enum logic [3:0] {
    INIT, ALU_PROC, JUMP_COND_S, INC_QCLK_S, ALU_FPROC_WAIT,
    JUMP_FPROC_WAIT, SYNC_WAIT, HALT, ERR
  } state_t;

  localparam logic [1:0] SEL_QCLK  = 2'b00;
  localparam logic [1:0] SEL_REG   = 2'b01;
  localparam logic [1:0] SEL_FPROC = 2'b10;

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_FPROC   = 2'b10;
  localparam logic [1:0] ERR_SYNC    = 2'b11;

  localparam bit              TO_EN   = (WAIT_TIMEOUT > 0);
  localparam int              TO_LAST = (WAIT_TIMEOUT > 0) ? WAIT_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] TO_CMP = CNT_W'(TO_LAST);

  state_t           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic             from_fproc;
  logic [1:0]       err_code_next;
  logic             in_wait;
  logic             expired;

  assign alu_opcode  = opcode[2:0];
  assign alu_in0_sel = opcode[3];
  assign in_wait     = (state == ALU_FPROC_WAIT) || (state == JUMP_FPROC_WAIT) ||
                       (state == SYNC_WAIT);
  assign expired     = TO_EN && (wait_cnt == TO_CMP);
  assign done        = (state == HALT);
  assign err         = (state == ERR);

  // State register, wait counter (zero on every wait entry since waits are only entered from INIT)
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= INIT;
      wait_cnt   <= '0;
      from_fproc <= 1'b0;
      err_code   <= 2'b00;
    end else begin
      state      <= state_next;
      wait_cnt   <= in_wait ? wait_cnt + CNT_W'(1) : '0;
      from_fproc <= (state == ALU_FPROC_WAIT) || (state == JUMP_FPROC_WAIT);
      if (state != ERR && state_next == ERR)
        err_code <= err_code_next;
    end
  end

  always_comb begin
    state_next        = state;
    err_code_next     = 2'b00;
    alu_in1_sel       = SEL_REG;
    c_strobe_enable   = 1'b0;
    reg_write_en      = 1'b0;
    instr_ptr_en      = 1'b0;
    instr_ptr_load_en = 2'b00;
    qclk_load_en      = 1'b0;
    sync_out_ready    = 1'b0;
    fproc_out_ready   = 1'b0;
    write_pulse_en    = 1'b0;

    unique case (state)
      INIT: begin
        case (opcode[7:4])
          4'h0: instr_ptr_en = 1'b1;
          4'h1: state_next = ALU_PROC;
          4'h2: begin
            instr_ptr_en      = 1'b1;
            instr_ptr_load_en = 2'b01;
          end
          4'h3: state_next = JUMP_COND_S;
          4'h4: begin
            fproc_out_ready = 1'b1;
            state_next      = ALU_FPROC_WAIT;
          end
          4'h5: begin
            fproc_out_ready = 1'b1;
            state_next      = JUMP_FPROC_WAIT;
          end
          4'h6: begin
            alu_in1_sel = SEL_QCLK;
            state_next  = INC_QCLK_S;
          end
          4'h7: begin
            sync_out_ready = 1'b1;
            state_next     = SYNC_WAIT;
          end
          4'h8: begin
            write_pulse_en = 1'b1;
            instr_ptr_en   = 1'b1;
          end
          4'h9: begin
            // Trigger stalls the pointer until the pulse path strobes
            write_pulse_en  = 1'b1;
            c_strobe_enable = 1'b1;
            instr_ptr_en    = cstrobe_in;
          end
          4'hA: state_next = HALT;
          default: begin
            if (ILLEGAL_TRAP != 0) begin
              state_next    = ERR;
              err_code_next = ERR_ILLEGAL;
            end else begin
              instr_ptr_en = 1'b1;
            end
          end
        endcase
      end
      ALU_PROC: begin
        alu_in1_sel  = from_fproc ? SEL_FPROC : SEL_REG;
        reg_write_en = 1'b1;
        instr_ptr_en = 1'b1;
        state_next   = INIT;
      end
      JUMP_COND_S: begin
        alu_in1_sel       = from_fproc ? SEL_FPROC : SEL_REG;
        instr_ptr_en      = 1'b1;
        instr_ptr_load_en = 2'b10;
        state_next        = INIT;
      end
      INC_QCLK_S: begin
        alu_in1_sel  = SEL_QCLK;
        qclk_load_en = 1'b1;
        instr_ptr_en = 1'b1;
        state_next   = INIT;
      end
      ALU_FPROC_WAIT, JUMP_FPROC_WAIT: begin
        alu_in1_sel = SEL_FPROC;
        if (fproc_ready) begin
          state_next = (state == ALU_FPROC_WAIT) ? ALU_PROC : JUMP_COND_S;
        end else if (expired) begin
          state_next    = ERR;
          err_code_next = ERR_FPROC;
        end
      end
      SYNC_WAIT: begin
        if (sync_enable) begin
          instr_ptr_en = 1'b1;
          state_next   = INIT;
        end else if (expired) begin
          state_next    = ERR;
          err_code_next = ERR_SYNC;
        end
      end
      HALT:    state_next = HALT;
      ERR:     state_next = ERR;
      default: state_next = INIT;
    endcase

    if (reset) begin
      c_strobe_enable   = 1'b0;
      reg_write_en      = 1'b0;
      instr_ptr_en      = 1'b0;
      instr_ptr_load_en = 2'b00;
      qclk_load_en      = 1'b0;
      sync_out_ready    = 1'b0;
      fproc_out_ready   = 1'b0;
      write_pulse_en    = 1'b0;
    end
  end

endmodule

// File: tb/tb_proc_ctrl_seq.sv
// Directed bench for proc_ctrl_seq: one trapping instance with an 8-cycle timeout,
// one non-trapping instance with a 3-cycle timeout, sharing all inputs.
module tb_proc_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] opcode;
  logic       fproc_ready, sync_enable, cstrobe_in;

  logic [2:0] aop_a, aop_b;
  logic       in0_a, in0_b;
  logic [1:0] sel_a, sel_b, ld_a, ld_b, code_a, code_b;
  logic       cse_a, rwe_a, ipe_a, qle_a, sor_a, for_a, wpe_a, done_a, err_a;
  logic       cse_b, rwe_b, ipe_b, qle_b, sor_b, for_b, wpe_b, done_b, err_b;

  logic [6:0] en_a, en_b;
  assign en_a = {cse_a, rwe_a, ipe_a, qle_a, sor_a, for_a, wpe_a};
  assign en_b = {cse_b, rwe_b, ipe_b, qle_b, sor_b, for_b, wpe_b};

  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] CSE  = 7'b1000000;
  localparam logic [6:0] RWE  = 7'b0100000;
  localparam logic [6:0] IPE  = 7'b0010000;
  localparam logic [6:0] QLE  = 7'b0001000;
  localparam logic [6:0] SOR  = 7'b0000100;
  localparam logic [6:0] FOR  = 7'b0000010;
  localparam logic [6:0] WPE  = 7'b0000001;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  proc_ctrl_seq #(.WAIT_TIMEOUT(8), .CNT_W(16), .ILLEGAL_TRAP(1)) dut_a (
    .clk(clk), .reset(reset), .opcode(opcode), .fproc_ready(fproc_ready),
    .sync_enable(sync_enable), .cstrobe_in(cstrobe_in),
    .alu_opcode(aop_a), .alu_in0_sel(in0_a), .alu_in1_sel(sel_a),
    .c_strobe_enable(cse_a), .reg_write_en(rwe_a), .instr_ptr_en(ipe_a),
    .instr_ptr_load_en(ld_a), .qclk_load_en(qle_a), .sync_out_ready(sor_a),
    .fproc_out_ready(for_a), .write_pulse_en(wpe_a), .done(done_a), .err(err_a),
    .err_code(code_a)
  );

  proc_ctrl_seq #(.WAIT_TIMEOUT(3), .CNT_W(8), .ILLEGAL_TRAP(0)) dut_b (
    .clk(clk), .reset(reset), .opcode(opcode), .fproc_ready(fproc_ready),
    .sync_enable(sync_enable), .cstrobe_in(cstrobe_in),
    .alu_opcode(aop_b), .alu_in0_sel(in0_b), .alu_in1_sel(sel_b),
    .c_strobe_enable(cse_b), .reg_write_en(rwe_b), .instr_ptr_en(ipe_b),
    .instr_ptr_load_en(ld_b), .qclk_load_en(qle_b), .sync_out_ready(sor_b),
    .fproc_out_ready(for_b), .write_pulse_en(wpe_b), .done(done_b), .err(err_b),
    .err_code(code_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_all();
    reset       = 1'b1;
    opcode      = 8'h00;
    fproc_ready = 1'b0;
    sync_enable = 1'b0;
    cstrobe_in  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state: enables forced low even with NOP presented
    reset_all();
    reset = 1'b1;
    #1;
    check("rst_en", en_a, NONE);
    check("rst_done", done_a, 0);
    check("rst_err", err_a, 0);
    check("rst_code", code_a, 0);
    check("rst_sel", sel_a, 2'b01);
    reset = 1'b0;
    #1;
    check("nop_en", en_a, IPE);

    // REG_ALU 0x11
    opcode = 8'h11;
    #1;
    check("regalu_c1_en", en_a, NONE);
    check("regalu_c1_sel", sel_a, 2'b01);
    check("regalu_aop", aop_a, 3'd1);
    check("regalu_in0", in0_a, 0);
    tick();
    opcode = 8'h00;
    #1;
    check("regalu_c2_en", en_a, RWE | IPE);
    check("regalu_c2_sel", sel_a, 2'b01);
    tick();
    #1;
    check("regalu_c3_en", en_a, IPE);
    opcode = 8'h1F;
    #1;
    check("aop_7", aop_a, 3'd7);
    check("in0_1", in0_a, 1);
    opcode = 8'h00;

    // JUMP_FPROC 0x53, ready after 4 wait cycles
    opcode = 8'h53;
    #1;
    check("jf_req_en", en_a, FOR);
    tick();
    opcode = 8'h00;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("jf_wait_en", en_a, NONE);
      check("jf_wait_sel", sel_a, 2'b10);
      tick();
    end
    fproc_ready = 1'b1;
    #1;
    check("jf_rdy_sel", sel_a, 2'b10);
    check("jf_rdy_en", en_a, NONE);
    tick();
    fproc_ready = 1'b0;
    #1;
    check("jf_jc_en", en_a, IPE);
    check("jf_jc_ld", ld_a, 2'b10);
    check("jf_jc_sel", sel_a, 2'b10);
    tick();
    #1;
    check("jf_back_en", en_a, IPE);
    check("jf_back_ld", ld_a, 2'b00);

    // JUMP_COND 0x30 direct: operand from register
    opcode = 8'h30;
    #1;
    check("jc_c1_en", en_a, NONE);
    tick();
    opcode = 8'h00;
    #1;
    check("jc_en", en_a, IPE);
    check("jc_ld", ld_a, 2'b10);
    check("jc_sel", sel_a, 2'b01);
    tick();

    // ALU_FPROC 0x41, ready on second wait cycle
    opcode = 8'h41;
    tick();
    opcode = 8'h00;
    tick();
    fproc_ready = 1'b1;
    tick();
    fproc_ready = 1'b0;
    #1;
    check("af_alu_en", en_a, RWE | IPE);
    check("af_alu_sel", sel_a, 2'b10);
    tick();

    // INC_QCLK 0x60
    opcode = 8'h60;
    #1;
    check("iq_c1_sel", sel_a, 2'b00);
    check("iq_c1_en", en_a, NONE);
    tick();
    opcode = 8'h00;
    #1;
    check("iq_c2_en", en_a, QLE | IPE);
    check("iq_c2_sel", sel_a, 2'b00);
    tick();

    // JUMP_I 0x20 and PULSE_WRITE 0x80
    opcode = 8'h20;
    #1;
    check("ji_en", en_a, IPE);
    check("ji_ld", ld_a, 2'b01);
    tick();
    opcode = 8'h80;
    #1;
    check("pw_en", en_a, WPE | IPE);
    tick();

    // PULSE_WRITE_TRIG 0x90: stall 3 cycles, advance on strobe
    opcode = 8'h90;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("pwt_stall_en", en_a, CSE | WPE);
      tick();
    end
    cstrobe_in = 1'b1;
    #1;
    check("pwt_go_en", en_a, CSE | WPE | IPE);
    tick();
    cstrobe_in = 1'b0;
    opcode = 8'h00;

    // ALU_FPROC timeout on the 8-cycle instance
    reset_all();
    opcode = 8'h41;
    tick();
    opcode = 8'h00;
    for (int i = 0; i < 8; i++) begin
      #1;
      check("afto_wait_err", err_a, 0);
      tick();
    end
    #1;
    check("afto_err", err_a, 1);
    check("afto_code", code_a, 2'b10);
    opcode = 8'h11;
    fproc_ready = 1'b1;
    #1;
    check("afto_ignore_en", en_a, NONE);
    tick();
    #1;
    check("afto_sticky", err_a, 1);
    check("afto_sticky_en", en_a, NONE);
    fproc_ready = 1'b0;

    // SYNC release on the expiry cycle (3-cycle instance)
    reset_all();
    opcode = 8'h70;
    #1;
    check("sync_req_b", en_b, SOR);
    tick();
    opcode = 8'h00;
    #1;
    check("sync_w0_b", en_b, NONE);
    tick();
    #1;
    check("sync_w1_b", en_b, NONE);
    tick();
    sync_enable = 1'b1;
    #1;
    check("sync_rel_en_b", en_b, IPE);
    tick();
    sync_enable = 1'b0;
    #1;
    check("sync_rel_err_b", err_b, 0);
    check("sync_init_b", en_b, IPE);

    // SYNC timeout on the 3-cycle instance
    opcode = 8'h70;
    tick();
    opcode = 8'h00;
    tick();
    tick();
    #1;
    check("syto_pre_err_b", err_b, 0);
    tick();
    #1;
    check("syto_err_b", err_b, 1);
    check("syto_code_b", code_b, 2'b11);

    // DONE then further opcode ignored; reset recovers
    reset_all();
    opcode = 8'hA0;
    tick();
    opcode = 8'h11;
    #1;
    check("done_flag", done_a, 1);
    check("done_en", en_a, NONE);
    tick();
    #1;
    check("done_sticky", done_a, 1);
    check("done_sticky_en", en_a, NONE);
    reset_all();
    #1;
    check("done_cleared", done_a, 0);
    check("done_reinit_en", en_a, IPE);

    // Illegal class: trap on instance a, NOP on instance b
    opcode = 8'hF0;
    #1;
    check("ill_en_a", en_a, NONE);
    check("ill_en_b", en_b, IPE);
    tick();
    opcode = 8'h00;
    #1;
    check("ill_err_a", err_a, 1);
    check("ill_code_a", code_a, 2'b01);
    check("ill_err_b", err_b, 0);
    check("ill_next_b", en_b, IPE);

    // Reset in the middle of an fproc wait: no write
    reset_all();
    opcode = 8'h41;
    tick();
    opcode = 8'h00;
    #1;
    check("mid_wait_sel", sel_a, 2'b10);
    tick();
    reset = 1'b1;
    fproc_ready = 1'b1;
    #1;
    check("mid_rst_en", en_a, NONE);
    tick();
    reset = 1'b0;
    fproc_ready = 1'b0;
    #1;
    check("mid_rst_init", en_a, IPE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_ctrl_seq.md
Name: proc_ctrl_seq

Overview:
- Multi-cycle instruction sequencer for one distributed-processor core; second-generation replacement for the current control FSM.
- Decodes the 8-bit opcode from the command buffer and drives ALU operand selects, register-file write, instruction-pointer enable/load, qclk load, pulse-write enable and the fproc/sync handshakes.
- Adds three things: a SYNC barrier state, a DONE/halt state, and a parametrised wait-timeout with error reporting.
- All outputs are fully defined in every state: no latches, no undriven selects.

Parameters:
- WAIT_TIMEOUT, 0: cycles allowed in any fproc/sync wait state before error. 0 disables the timeout.
- CNT_W, 16: width of the wait counter. Requires WAIT_TIMEOUT < 2**CNT_W.
- ILLEGAL_TRAP, 1: 1 = an undefined opcode class goes to ERR. 0 = it is treated as NOP (instr_ptr_en=1 for one cycle).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- opcode  in  8  current instruction opcode: [7:4] class, [3] in0 select, [2:0] ALU op
- fproc_ready  in  1  fproc result valid
- sync_enable  in  1  sync barrier release
- cstrobe_in  in  1  pulse trigger strobe from the pulse path
- alu_opcode  out  3  = opcode[2:0] (combinational)
- alu_in0_sel  out  1  = opcode[3]
- alu_in1_sel  out  2  00 qclk, 01 reg, 10 fproc
- c_strobe_enable  out  1  arm pulse trigger
- reg_write_en  out  1  register-file write
- instr_ptr_en  out  1  advance/load instruction pointer
- instr_ptr_load_en  out  2  00 increment, 01 load immediate, 10 load from ALU result
- qclk_load_en  out  1  load qclk from ALU
- sync_out_ready  out  1  request sync (one-cycle pulse)
- fproc_out_ready  out  1  request fproc (one-cycle pulse)
- write_pulse_en  out  1  pulse register write
- done  out  1  core halted by DONE
- err  out  1  core in error
- err_code  out  2  01 illegal opcode, 10 fproc timeout, 11 sync timeout

Behaviour:
- Opcode classes:
  - 0001 REG_ALU, 0010 JUMP_I, 0011 JUMP_COND, 0100 ALU_FPROC, 0101 JUMP_FPROC, 0110 INC_QCLK, 0111 SYNC
  - 1000 PULSE_WRITE, 1001 PULSE_WRITE_TRIG, 1010 DONE
  - 0000 NOP
  - all other classes are illegal
- Output defaults in every state unless overridden below: every enable 0, instr_ptr_load_en=00, alu_in1_sel=01.
- States: INIT, ALU_PROC, JUMP_COND_S, INC_QCLK_S, ALU_FPROC_WAIT, JUMP_FPROC_WAIT, SYNC_WAIT, HALT, ERR. Outputs are combinational from state plus opcode (Mealy). State is registered.
- Reset:
  - State becomes INIT; wait counter, done, err and err_code clear to 0.
  - While reset is high, every enable output is forced to 0.
- INIT decode:
  - NOP: instr_ptr_en=1, stay in INIT.
  - PULSE_WRITE: write_pulse_en=1, instr_ptr_en=1, stay in INIT.
  - PULSE_WRITE_TRIG: write_pulse_en=1, c_strobe_enable=1, instr_ptr_en=cstrobe_in, stay in INIT. The trigger stalls until the strobe arrives.
  - REG_ALU: alu_in1_sel=01, go to ALU_PROC.
  - JUMP_I: instr_ptr_en=1, load=01, stay in INIT.
  - JUMP_COND: alu_in1_sel=01, go to JUMP_COND_S.
  - INC_QCLK: alu_in1_sel=00, go to INC_QCLK_S.
  - ALU_FPROC: fproc_out_ready=1, go to ALU_FPROC_WAIT.
  - JUMP_FPROC: fproc_out_ready=1, go to JUMP_FPROC_WAIT.
  - SYNC: sync_out_ready=1, go to SYNC_WAIT.
  - DONE: go to HALT.
  - Illegal: go to ERR with err_code=01, or behave as NOP when ILLEGAL_TRAP=0.
- Execute states (single cycle each, then back to INIT):
  - ALU_PROC: reg_write_en=1, instr_ptr_en=1.
  - JUMP_COND_S: instr_ptr_en=1, load=10. This state holds alu_in1_sel=10 when entered from an fproc wait, 01 otherwise; track the origin with one registered bit.
  - INC_QCLK_S: alu_in1_sel=00, qclk_load_en=1, instr_ptr_en=1.
- Fproc waits:
  - In both wait states: alu_in1_sel=10; the counter increments each cycle.
  - On fproc_ready: ALU_FPROC_WAIT goes to ALU_PROC (alu_in1_sel held at 10 there), JUMP_FPROC_WAIT goes to JUMP_COND_S.
- SYNC_WAIT: on sync_enable, instr_ptr_en=1 and go to INIT.
- Timeout:
  - Applies only when WAIT_TIMEOUT>0.
  - If the counter equals WAIT_TIMEOUT-1 and the ready/enable input is low, go to ERR. err_code=10 for fproc waits, 11 for sync.
  - If ready/enable arrives in the same cycle as expiry, ready wins.
  - The counter clears on every entry to a wait state.
- HALT and ERR:
  - Sticky until reset; all enables 0.
  - done=1 in HALT; err=1 in ERR.
  - fproc_ready and sync_enable are ignored.
- Latency (cycles from INIT until instr_ptr_en):
  - REG_ALU / JUMP_COND / INC_QCLK: 2.
  - JUMP_I / PULSE_WRITE / NOP: 1.
  - fproc: 2 + wait cycles.
- Reset asserted mid-wait: the next state is INIT and no pending write occurs.

Test Plan:
- REG_ALU opcode 0x11 (class 0001, in0=0, op ADD) -> cycle 1: alu_in1_sel=01 with no writes; cycle 2: reg_write_en=1, instr_ptr_en=1; cycle 3: back in INIT.
- JUMP_FPROC 0x53, fproc_ready high after 4 cycles, WAIT_TIMEOUT=8 -> fproc_out_ready pulses once; alu_in1_sel=10 for 5 cycles; then instr_ptr_load_en=10 with instr_ptr_en=1.
- ALU_FPROC, fproc_ready never asserted, WAIT_TIMEOUT=8 -> ERR after 8 wait cycles; err=1, err_code=10; further opcodes ignored until reset.
- SYNC 0x70, sync_enable high on the same cycle the timeout expires (WAIT_TIMEOUT=3) -> instr_ptr_en=1, return to INIT, err stays 0.
- PULSE_WRITE_TRIG 0x90, cstrobe_in low for 3 cycles then high -> write_pulse_en=1 and c_strobe_enable=1 for 4 cycles; instr_ptr_en=1 only on the 4th.
- DONE 0xA0, then opcode 0x11 -> done=1 and all enables stay 0; reset returns to INIT. Opcode 0xF0 with ILLEGAL_TRAP=1 -> err_code=01.
